// File: rtl/mem_responder.sv
// Memory-side responder for the processor command/ready bus.
// One word-addressed unified RAM serves instruction fetch plus an
// optional data read or byte-masked write per command. Bus faults are
// latched on the error output and freeze the responder until reset.
module mem_responder #(
   parameter int ADDR_W      = 12,
   parameter int LATENCY     = 2,
   parameter int INIT_CYCLES = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [2:0]  command,
   input  logic [31:0] pc,
   input  logic [31:0] data_addr,
   input  logic [31:0] data_wdata,
   input  logic [3:0]  data_wstrb,
   output logic        ready,
   output logic [31:0] inst_rdata,
   output logic [31:0] data_rdata,
   output logic        mem_start_ready,
   output logic [1:0]  error
);

   localparam int DEPTH = 2 ** ADDR_W;

   typedef enum logic [1:0] {
      INIT,
      IDLE,
      BUSY,
      FAULT
   } state_t;

   state_t state, next_state;
   logic [7:0] count, next_count;

   logic [2:0]        cmd_q;
   logic [ADDR_W-1:0] pc_idx_q;
   logic [ADDR_W-1:0] data_idx_q;
   logic [31:0]       wdata_q;
   logic [3:0]        wstrb_q;

   logic [31:0] mem [DEPTH];

   logic        accept;
   logic        complete;
   logic        do_write;
   logic        uses_data;
   logic        pc_oor;
   logic        data_oor;
   logic [1:0]  fault_code;
   logic [31:0] merged_word;
   logic [31:0] fetch_word;

   // The byte offset of the PC is irrelevant: whole words are always fetched.
   logic unused_pc_bits;
   assign unused_pc_bits = ^pc[1:0];

   assign uses_data = (command == 3'd2) || (command == 3'd3);
   assign pc_oor    = |pc[31:ADDR_W+2];
   assign data_oor  = |data_addr[31:ADDR_W+2];
   assign do_write  = complete && (cmd_q == 3'd3);

   // Classify the presented command by fault priority: illegal opcode,
   // then address range, then misaligned full-word write.
   always_comb begin
      fault_code = 2'd0;
      if (command >= 3'd5) begin
         fault_code = 2'd3;
      end else if (pc_oor || (uses_data && data_oor)) begin
         fault_code = 2'd1;
      end else if ((command == 3'd3) && (data_wstrb == 4'hF) && (data_addr[1:0] != 2'd0)) begin
         fault_code = 2'd2;
      end
   end

   // Merge write lanes into the stored word; a fetch of the same word
   // must see the merged value because the write logically comes first.
   always_comb begin
      merged_word = mem[data_idx_q];
      for (int lane = 0; lane < 4; lane++) begin
         if (wstrb_q[lane]) begin
            merged_word[8*lane +: 8] = wdata_q[8*lane +: 8];
         end
      end
      if (do_write && (pc_idx_q == data_idx_q)) begin
         fetch_word = merged_word;
      end else begin
         fetch_word = mem[pc_idx_q];
      end
   end

   // Next-state logic: start-up countdown, command accept, latency countdown.
   always_comb begin
      next_state = state;
      next_count = count;
      accept     = 1'b0;
      complete   = 1'b0;
      case (state)
         INIT: begin
            if (count == 8'(INIT_CYCLES - 1)) begin
               next_state = IDLE;
               next_count = 8'd0;
            end else begin
               next_count = count + 8'd1;
            end
         end
         IDLE: begin
            if (ready && (command != 3'd0)) begin
               accept     = 1'b1;
               next_count = 8'd0;
               next_state = (fault_code != 2'd0) ? FAULT : BUSY;
            end
         end
         BUSY: begin
            if (count == 8'(LATENCY - 1)) begin
               complete   = 1'b1;
               next_state = IDLE;
               next_count = 8'd0;
            end else begin
               next_count = count + 8'd1;
            end
         end
         FAULT: begin
            next_state = FAULT;
         end
         default: begin
            next_state = INIT;
            next_count = 8'd0;
         end
      endcase
   end

   // State and cycle counter register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= INIT;
         count <= 8'd0;
      end else begin
         state <= next_state;
         count <= next_count;
      end
   end

   // Handshake outputs, command latches, sticky error and response data.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ready           <= 1'b0;
         mem_start_ready <= 1'b0;
         error           <= 2'd0;
         inst_rdata      <= 32'd0;
         data_rdata      <= 32'd0;
         cmd_q           <= 3'd0;
         pc_idx_q        <= '0;
         data_idx_q      <= '0;
         wdata_q         <= 32'd0;
         wstrb_q         <= 4'd0;
      end else begin
         if ((state == INIT) && (next_state == IDLE)) begin
            ready           <= 1'b1;
            mem_start_ready <= 1'b1;
         end
         if (accept) begin
            ready      <= 1'b0;
            cmd_q      <= command;
            pc_idx_q   <= pc[ADDR_W+1:2];
            data_idx_q <= data_addr[ADDR_W+1:2];
            wdata_q    <= data_wdata;
            wstrb_q    <= data_wstrb;
            error      <= fault_code;
         end
         if (complete) begin
            ready      <= 1'b1;
            inst_rdata <= fetch_word;
            if (cmd_q == 3'd2) begin
               data_rdata <= mem[data_idx_q];
            end
         end
      end
   end

   // RAM write port; contents deliberately survive reset.
   always_ff @(posedge clk) begin
      if (do_write) begin
         mem[data_idx_q] <= merged_word;
      end
   end

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: directed scenarios plus a
// randomized command stream checked against a word-array memory model.
module tb_mem_responder;

   localparam int LATENCY     = 2;
   localparam int INIT_CYCLES = 8;

   logic        clk;
   logic        rst;
   logic [2:0]  command;
   logic [31:0] pc;
   logic [31:0] data_addr;
   logic [31:0] data_wdata;
   logic [3:0]  data_wstrb;
   logic        ready;
   logic [31:0] inst_rdata;
   logic [31:0] data_rdata;
   logic        mem_start_ready;
   logic [1:0]  error;

   int testsRun;
   int testsFailed;

   logic [31:0] modelRam [64];
   logic [31:0] expInst;
   logic [31:0] expData;

   logic [2:0]  rc;
   logic [31:0] rp;
   logic [31:0] ra;
   logic [31:0] rw;
   logic [3:0]  rs;

   mem_responder #(
      .ADDR_W(12),
      .LATENCY(LATENCY),
      .INIT_CYCLES(INIT_CYCLES)
   ) dut (
      .clk(clk),
      .rst(rst),
      .command(command),
      .pc(pc),
      .data_addr(data_addr),
      .data_wdata(data_wdata),
      .data_wstrb(data_wstrb),
      .ready(ready),
      .inst_rdata(inst_rdata),
      .data_rdata(data_rdata),
      .mem_start_ready(mem_start_ready),
      .error(error)
   );

   // Free-running clock, 10 time units per cycle.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One comparison: counts it, and reports tag/observed/expected on mismatch.
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      testsRun++;
      assert (observed === expected) else begin
         testsFailed++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
      end
   endtask

   // Present a command at a falling edge and hold it across one rising edge.
   task automatic applyStimulus(input logic [2:0] c, input logic [31:0] p, input logic [31:0] a,
                                input logic [31:0] w, input logic [3:0] s);
      command    = c;
      pc         = p;
      data_addr  = a;
      data_wdata = w;
      data_wstrb = s;
      @(negedge clk);
      command = 3'd0;
   endtask

   // Count low-ready cycles until the response arrives, bounded.
   task automatic waitReady(output int cycles);
      cycles = 0;
      while ((ready !== 1'b1) && (cycles < 40)) begin
         @(negedge clk);
         cycles++;
      end
   endtask

   // Assert reset, check cleared outputs, release and time the start-up.
   task automatic doReset(input string tag);
      int cycles;
      logic errSeen;
      rst = 1'b1;
      command = 3'd0;
      #1;
      checkOutput({tag, "_rst_ready"}, {31'd0, ready}, 32'd0);
      checkOutput({tag, "_rst_msr"}, {31'd0, mem_start_ready}, 32'd0);
      checkOutput({tag, "_rst_error"}, {30'd0, error}, 32'd0);
      checkOutput({tag, "_rst_inst"}, inst_rdata, 32'd0);
      checkOutput({tag, "_rst_data"}, data_rdata, 32'd0);
      expInst = 32'd0;
      expData = 32'd0;
      @(negedge clk);
      rst = 1'b0;
      cycles = 0;
      errSeen = 1'b0;
      do begin
         @(negedge clk);
         cycles++;
         if (error !== 2'd0) errSeen = 1'b1;
      end while ((mem_start_ready !== 1'b1) && (cycles < 30));
      checkOutput({tag, "_init_cycles"}, cycles, INIT_CYCLES);
      checkOutput({tag, "_init_ready"}, {31'd0, ready}, 32'd1);
      checkOutput({tag, "_init_error"}, {31'd0, errSeen}, 32'd0);
   endtask

   // Issue a legal command, update the memory model, check latency and data.
   task automatic runOp(input string tag, input logic [2:0] c, input logic [31:0] p, input logic [31:0] a,
                        input logic [31:0] w, input logic [3:0] s);
      int cycles;
      int pIdx;
      int aIdx;
      pIdx = int'(p[7:2]);
      aIdx = int'(a[7:2]);
      if (c == 3'd3) begin
         for (int lane = 0; lane < 4; lane++) begin
            if (s[lane]) modelRam[aIdx][8*lane +: 8] = w[8*lane +: 8];
         end
      end
      expInst = modelRam[pIdx];
      if (c == 3'd2) expData = modelRam[aIdx];
      applyStimulus(c, p, a, w, s);
      waitReady(cycles);
      checkOutput({tag, "_latency"}, cycles, LATENCY);
      checkOutput({tag, "_inst"}, inst_rdata, expInst);
      checkOutput({tag, "_data"}, data_rdata, expData);
   endtask

   // Issue a faulting command, check the sticky error, then reset.
   task automatic faultOp(input string tag, input logic [2:0] c, input logic [31:0] p, input logic [31:0] a,
                          input logic [31:0] w, input logic [3:0] s, input logic [1:0] expErr);
      applyStimulus(c, p, a, w, s);
      checkOutput({tag, "_error"}, {30'd0, error}, {30'd0, expErr});
      checkOutput({tag, "_ready"}, {31'd0, ready}, 32'd0);
      repeat (4) @(negedge clk);
      checkOutput({tag, "_error_sticky"}, {30'd0, error}, {30'd0, expErr});
      checkOutput({tag, "_ready_held"}, {31'd0, ready}, 32'd0);
      doReset({tag, "_recover"});
   endtask

   // Directed scenarios followed by randomized traffic and fault cases.
   initial begin
      testsRun    = 0;
      testsFailed = 0;
      expInst     = 32'd0;
      expData     = 32'd0;
      rst         = 1'b1;
      command     = 3'd0;
      pc          = 32'd0;
      data_addr   = 32'd0;
      data_wdata  = 32'd0;
      data_wstrb  = 4'd0;
      @(negedge clk);
      doReset("startup");

      for (int i = 0; i < 64; i++) begin
         runOp("preload", 3'd3, 32'(i * 4), 32'(i * 4), $urandom, 4'hF);
      end

      runOp("deadbeef_wr", 3'd3, 32'd12, 32'd12, 32'hDEAD_BEEF, 4'hF);
      runOp("deadbeef_rd", 3'd1, 32'd12, 32'd0, 32'd0, 4'd0);
      checkOutput("deadbeef_value", inst_rdata, 32'hDEAD_BEEF);

      runOp("lane_clear", 3'd3, 32'd0, 32'h20, 32'd0, 4'hF);
      runOp("lane_write", 3'd3, 32'd0, 32'h20, 32'hAABB_CCDD, 4'b0100);
      runOp("lane_read", 3'd2, 32'd0, 32'h22, 32'd0, 4'd0);
      checkOutput("lane_value", data_rdata, 32'h00BB_0000);
      runOp("nop_write", 3'd3, 32'd0, 32'h20, 32'hFFFF_FFFF, 4'd0);
      runOp("nop_read", 3'd2, 32'd0, 32'h20, 32'd0, 4'd0);
      checkOutput("nop_value", data_rdata, 32'h00BB_0000);

      runOp("wr_fwd", 3'd3, 32'h40, 32'h40, 32'h1234_5678, 4'hF);
      checkOutput("wr_fwd_value", inst_rdata, 32'h1234_5678);
      runOp("irq_fetch", 3'd4, 32'h43, 32'h0001_0000, 32'd0, 4'd0);
      runOp("half_misalign", 3'd3, 32'd4, 32'h21, 32'h5566_7788, 4'h3);

      for (int i = 0; i < 40; i++) begin
         rc = 3'($urandom_range(1, 4));
         rp = {24'd0, 6'($urandom_range(0, 63)), 2'($urandom_range(0, 3))};
         ra = {24'd0, 6'($urandom_range(0, 63)), 2'($urandom_range(0, 3))};
         if ((i % 5) == 0) ra = rp;
         rw = $urandom;
         rs = 4'($urandom_range(0, 15));
         if ((rc == 3'd3) && (rs == 4'hF)) ra[1:0] = 2'd0;
         runOp("rand", rc, rp, ra, rw, rs);
      end

      faultOp("oor_data", 3'd2, 32'd0, 32'h0001_0000, 32'd0, 4'd0, 2'd1);
      faultOp("oor_pc", 3'd1, 32'h0000_4000, 32'd0, 32'd0, 4'd0, 2'd1);
      faultOp("illegal6", 3'd6, 32'd0, 32'd0, 32'd0, 4'd0, 2'd3);
      faultOp("illegal_prio", 3'd7, 32'h0000_4000, 32'd0, 32'd0, 4'd0, 2'd3);
      faultOp("misalign", 3'd3, 32'd0, 32'h21, 32'hFFFF_FFFF, 4'hF, 2'd2);
      runOp("misalign_chk", 3'd2, 32'd0, 32'h20, 32'd0, 4'd0);

      applyStimulus(3'd3, 32'd0, 32'h40, 32'hCAFE_F00D, 4'hF);
      @(negedge clk);
      doReset("abort");
      runOp("abort_chk", 3'd2, 32'd0, 32'h40, 32'd0, 4'd0);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
